// File: rtl/clk_phase_seq_pkg.sv
// Shared types and default sizing for the clock phase sequencer.
// The state enumeration is used by the top-level FSM.
package clk_phase_seq_pkg;

  localparam int NCH_DEF     = 4;
  localparam int CW_DEF      = 8;
  localparam int CLR_CYC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/clk_phase_ch.sv
// One derived clock channel: a half-period down-counter that toggles cp.
// While stopping, it only keeps counting until cp is high again, then freezes.
module clk_phase_ch
  import clk_phase_seq_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          sys_clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  input  logic [CW-1:0] half_i,
  input  logic          load_i,
  input  logic          run_i,
  input  logic          stop_i,
  output logic          cp_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cp_q, cp_d;
  logic          advance;

  // A stopping channel only finishes a low phase; a high channel is already safe to freeze.
  assign advance = run_i || (stop_i && !cp_q);

  always_comb begin
    cnt_d = cnt_q;
    cp_d  = cp_q;
    if (!en_i) begin
      cp_d = 1'b1;
    end else if (load_i) begin
      cnt_d = half_i;
      cp_d  = 1'b1;
    end else if (advance) begin
      if (cnt_q <= CW'(1)) begin
        cp_d  = ~cp_q;
        cnt_d = half_i;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      cp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      cp_q  <= cp_d;
    end
  end

  assign cp_o = cp_q;

endmodule

// File: rtl/clk_phase_seq.sv
// Clock phase sequencer top: config registers, clear timer and run/stop FSM.
// Drives NCH derived clocks plus an active-low clear into a downstream netlist.
module clk_phase_seq
  import clk_phase_seq_pkg::*;
#(
  parameter  int NCH     = NCH_DEF,
  parameter  int CW      = CW_DEF,
  parameter  int CLR_CYC = CLR_CYC_DEF,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_half,
  input  logic           cfg_en,
  input  logic           start,
  input  logic           stop,
  output logic [NCH-1:0] cp,
  output logic           cd,
  output logic           busy
);

  localparam int CLRW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  state_e          state_q, state_d;
  logic [CLRW-1:0] clr_q, clr_d;
  logic            cd_q, cd_d;
  logic            load;
  logic [CW-1:0]   half_q [NCH];
  logic [CW-1:0]   half_d [NCH];
  logic [NCH-1:0]  en_q, en_d;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cd_d    = cd_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          clr_d   = '0;
          cd_d    = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_q == CLRW'(CLR_CYC - 1)) begin
          state_d = RUN;
          cd_d    = 1'b1;
          load    = 1'b1;
        end else begin
          clr_d = clr_q + CLRW'(1);
        end
      end
      RUN: begin
        if (stop) state_d = STOP;
      end
      STOP: begin
        if (&cp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A zero half-period is stored as 1 so channels never see a zero reload.
  always_comb begin
    half_d = half_q;
    en_d   = en_q;
    if ((state_q == IDLE) && cfg_valid) begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_ch == CHW'(i)) begin
          half_d[i] = (cfg_half == '0) ? CW'(1) : cfg_half;
          en_d[i]   = cfg_en;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q   <= '0;
      cd_q    <= 1'b0;
      en_q    <= '0;
      for (int i = 0; i < NCH; i++) half_q[i] <= CW'(1);
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cd_q    <= cd_d;
      en_q    <= en_d;
      half_q  <= half_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_phase_ch #(.CW(CW)) u_ch (
      .sys_clk_i (sys_clk),
      .reset_i   (reset),
      .en_i      (en_q[g]),
      .half_i    (half_q[g]),
      .load_i    (load),
      .run_i     (state_q == RUN),
      .stop_i    (state_q == STOP),
      .cp_o      (cp[g])
    );
  end

  assign cd        = cd_q;
  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q == IDLE);

endmodule

// File: tb/tb_clk_phase_seq.sv
// Directed bench for clk_phase_seq with hand-computed cp/cd/busy expectations.
// Inputs change 1ns after each rising edge; outputs are sampled at that point.
module tb_clk_phase_seq;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic       cfg_en;
  logic       start;
  logic       stop;
  logic [3:0] cp;
  logic       cd;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  clk_phase_seq dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_en    (cfg_en),
    .start     (start),
    .stop      (stop),
    .cp        (cp),
    .cd        (cd),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p);
    reset = r;
    start = s;
    stop  = p;
  endtask

  task automatic writeConfig(input logic [1:0] ch, input logic [7:0] half, input logic en);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = half;
    cfg_en    = en;
    checkOutput("cfg_ready_idle", cfg_ready, 1);
    stepCycle();
    cfg_valid = 1'b0;
  endtask

  // Called in the first CLEAR cycle; returns in the first RUN cycle.
  task automatic runClear();
    for (int c = 0; c < 4; c++) begin
      checkOutput("clear_cd", cd, 0);
      checkOutput("clear_cp", cp, 4'hF);
      checkOutput("clear_busy", busy, 1);
      stepCycle();
    end
    checkOutput("run_cd", cd, 1);
    checkOutput("run_busy", busy, 1);
  endtask

  initial begin
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;
    cfg_en    = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("rst_busy_override", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("idle_cp", cp, 4'hF);
    checkOutput("idle_cd", cd, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_ready", cfg_ready, 1);

    // Run 1: ch0 half=3; config and start attempts during RUN must be ignored.
    writeConfig(2'd0, 8'd3, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runClear();
    for (int k = 0; k < 24; k++) begin
      if (k >= 12 && k < 18) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd5; cfg_en = 1'b1; start = 1'b1;
        checkOutput("run_cfg_ready", cfg_ready, 0);
      end else begin
        cfg_valid = 1'b0; start = 1'b0;
      end
      checkOutput("run1_cp", cp, (((k / 3) % 2) == 0) ? 4'hF : 4'hE);
      stepCycle();
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    checkOutput("run1_cp_end", cp, 4'hF);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stop1_busy", busy, 1);
    checkOutput("stop1_cp", cp, 4'hF);
    stepCycle();
    checkOutput("idle1_busy", busy, 0);
    checkOutput("idle1_cd", cd, 1);

    // Run 2: ch0 half=5, ch1 half=0 (acts as 1); stop while cp[0] is low.
    writeConfig(2'd0, 8'd5, 1'b1);
    writeConfig(2'd1, 8'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runClear();
    for (int k = 0; k < 8; k++) begin
      checkOutput("run2_cp", cp, {2'b11, ((k % 2) == 0), (k < 5)});
      if (k == 7) stop = 1'b1;
      stepCycle();
    end
    stop = 1'b0;
    checkOutput("stop2_cp_a", cp, 4'hE);
    checkOutput("stop2_busy_a", busy, 1);
    checkOutput("stop2_cd", cd, 1);
    stepCycle();
    checkOutput("stop2_cp_b", cp, 4'hE);
    stepCycle();
    checkOutput("stop2_cp_c", cp, 4'hF);
    checkOutput("stop2_busy_c", busy, 1);
    stepCycle();
    checkOutput("idle2_busy", busy, 0);
    checkOutput("idle2_cd", cd, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("idle2_cp", cp, 4'hF);
      stepCycle();
    end

    // Run 3: start+stop together acts as start; then reset mid-RUN.
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runClear();
    for (int k = 0; k < 4; k++) begin
      checkOutput("run3_cp", cp, ((k % 2) == 0) ? 4'hF : 4'hD);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_cp", cp, 4'hF);
    checkOutput("midrst_cd", cd, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", cfg_ready, 1);

    // Run 4: config was cleared by reset, so every channel stays disabled.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runClear();
    for (int k = 0; k < 6; k++) begin
      checkOutput("run4_cp", cp, 4'hF);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stop4_busy", busy, 1);
    stepCycle();
    checkOutput("idle4_busy", busy, 0);
    checkOutput("idle4_cd", cd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
